// File: rtl/func_3_pkg.sv
// Shared widths and default truth tables for the func_3 decoder.
// Pure constants and types; no logic, no latency, no flow control.
package func_3_pkg;

    localparam int IDX_W = 4;
    localparam int TT_W  = 16;

    typedef logic [TT_W-1:0] tt_t;

    localparam tt_t TT_PARITY4 = 16'h6996;
    localparam tt_t TT_MAJ3OF4 = 16'hE880;

endpackage

// File: rtl/func_3_sync.sv
// Single-bit level synchroniser, STAGES flops deep; STAGES=0 is a plain wire.
// Latency STAGES cycles; free-running, no handshake or backpressure.
module func_3_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    generate
        if (STAGES < 0 || STAGES > 3) begin : g_bad_stages
            $error("func_3_sync: STAGES must be in 0..3");
        end

        if (STAGES == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign dout     = din;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= din;
                    for (int k = 1; k < STAGES; k++) begin
                        r_chain[k] <= r_chain[k-1];
                    end
                end
            end

            assign dout = r_chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/func_3.sv
// Two registered 4-input Boolean functions of synchronised levels a..d.
// Latency SYNC_STAGES+1 cycles; one index per cycle, no stall or backpressure.
module func_3
    import func_3_pkg::*;
#(
    parameter tt_t Y_TT        = TT_PARITY4,
    parameter tt_t Z_TT        = TT_MAJ3OF4,
    parameter int  SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y,
    output logic z
);

    logic             w_a_s;
    logic             w_b_s;
    logic             w_c_s;
    logic             w_d_s;
    logic [IDX_W-1:0] w_idx;
    logic             r_y;
    logic             r_z;

    func_3_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .din(a), .dout(w_a_s));
    func_3_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .din(b), .dout(w_b_s));
    func_3_sync #(.STAGES(SYNC_STAGES)) u_sync_c (.clk(clk), .rst_n(rst_n), .din(c), .dout(w_c_s));
    func_3_sync #(.STAGES(SYNC_STAGES)) u_sync_d (.clk(clk), .rst_n(rst_n), .din(d), .dout(w_d_s));

    assign w_idx = {w_a_s, w_b_s, w_c_s, w_d_s};

    // Both outputs load from the same index on the same edge, so they never mix samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= 1'b0;
            r_z <= 1'b0;
        end else begin
            r_y <= Y_TT[w_idx];
            r_z <= Z_TT[w_idx];
        end
    end

    assign y = r_y;
    assign z = r_z;

endmodule

// File: tb/tb_func_3.sv
// Directed bench for func_3: default tables, SYNC_STAGES=0 and custom tables side by side.
module tb_func_3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a     = 1'b0;
    logic b     = 1'b0;
    logic c     = 1'b0;
    logic d     = 1'b0;

    logic y_dflt, z_dflt;
    logic y_s0,   z_s0;
    logic y_cust, z_cust;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    func_3 u_dflt (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .y(y_dflt), .z(z_dflt)
    );

    func_3 #(.SYNC_STAGES(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .y(y_s0), .z(z_s0)
    );

    func_3 #(.Y_TT(16'h0001), .Z_TT(16'h8000)) u_cust (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .y(y_cust), .z(z_cust)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    initial begin
        logic [3:0] v;
        logic       exp_y;
        logic       exp_z;

        // Reset asserted between edges with all inputs high.
        set_in(4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_imm_y", y_dflt, 1'b0);
        check("rst_imm_z", z_dflt, 1'b0);
        check("rst_imm_s0_y", y_s0, 1'b0);
        tick(3);
        check("rst_hold_y", y_dflt, 1'b0);
        check("rst_hold_z", z_dflt, 1'b0);
        check("rst_hold_s0_z", z_s0, 1'b0);

        rst_n = 1'b1;
        tick(2);
        check("rel_e2_z", z_dflt, 1'b0);
        tick(1);
        check("rel_e3_y", y_dflt, 1'b0);
        check("rel_e3_z", z_dflt, 1'b1);

        // Exhaustive index sweep.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_in(v);
            tick(5);
            exp_y = v[0] ^ v[1] ^ v[2] ^ v[3];
            exp_z = ((v[0] + v[1] + v[2] + v[3]) >= 3) ? 1'b1 : 1'b0;
            check($sformatf("sweep%0d_y", i), y_dflt, exp_y);
            check($sformatf("sweep%0d_z", i), z_dflt, exp_z);
            check($sformatf("sweep%0d_s0_y", i), y_s0, exp_y);
            check($sformatf("sweep%0d_s0_z", i), z_s0, exp_z);
            check($sformatf("sweep%0d_cust_y", i), y_cust, (i == 0) ? 1'b1 : 1'b0);
            check($sformatf("sweep%0d_cust_z", i), z_cust, (i == 15) ? 1'b1 : 1'b0);
        end

        // Latency: 0000 -> 0001.
        set_in(4'b0000);
        tick(5);
        check("lat_base_y", y_dflt, 1'b0);
        set_in(4'b0001);
        tick(1);
        check("lat_s0_e1_y", y_s0, 1'b1);
        check("lat_e1_y", y_dflt, 1'b0);
        tick(1);
        check("lat_e2_y", y_dflt, 1'b0);
        tick(1);
        check("lat_e3_y", y_dflt, 1'b1);

        // Asynchronous reset pulse mid-stream with idx 7 (z=1).
        set_in(4'b0111);
        tick(5);
        check("mid_pre_z", z_dflt, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_async_z", z_dflt, 1'b0);
        check("mid_async_s0_z", z_s0, 1'b0);
        #4;
        rst_n = 1'b1;
        tick(1);
        check("mid_e1_z", z_dflt, 1'b0);
        check("mid_s0_e1_z", z_s0, 1'b1);
        tick(1);
        check("mid_e2_z", z_dflt, 1'b0);
        tick(1);
        check("mid_e3_z", z_dflt, 1'b1);

        // Coherence: 0000 -> 1111 in one step.
        set_in(4'b0000);
        tick(6);
        check("coh_base_z", z_dflt, 1'b0);
        set_in(4'b1111);
        tick(2);
        check("coh_e2_z", z_dflt, 1'b0);
        tick(1);
        for (int e = 4; e <= 6; e++) begin
            tick(1);
            check($sformatf("coh_e%0d_y", e), y_dflt, 1'b0);
            check($sformatf("coh_e%0d_z", e), z_dflt, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
